// File: rtl/rs232_mem_cmd.sv
// Byte-protocol command engine: 'W' ADDR DATA -> ACK, 'R' ADDR -> mem[ADDR], anything else -> NAK.
// Optional inter-byte timeout is enabled by defining RS232_MEM_TIMEOUT_EN.
module rs232_mem_cmd #(
   parameter int ADDR_W        = 8,
   parameter int TIMEOUT_TICKS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_rs232_en,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [7:0] tx_byte,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       busy,
   output logic       overrun
);

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_TX} state_t;

   state_t              r_state;
   logic                r_is_write;
   logic                r_nak;
   logic                r_seen_busy;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_data;
   logic [7:0]          r_reply;
   logic [7:0]          r_mem [2**ADDR_W];

   logic                w_addr_bad;
   logic                w_mem_we;

   assign w_addr_bad = (rx_byte >> ADDR_W) != 8'd0;
   assign w_mem_we   = (r_state == EXEC) && !r_nak && r_is_write;

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[r_addr] <= r_data;
   end

`ifdef RS232_MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0] r_tmo;
`else
   logic w_unused;
   assign w_unused = clk_rs232_en ^ (TIMEOUT_TICKS == 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         tx_byte     <= '0;
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         r_is_write  <= 1'b0;
         r_nak       <= 1'b0;
         r_seen_busy <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_reply     <= '0;
`ifdef RS232_MEM_TIMEOUT_EN
         r_tmo       <= '0;
`endif
      end else begin
         tx_start <= 1'b0;
         overrun  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rx_valid) begin
                  busy <= 1'b1;
                  if (!rx_err && (rx_byte == CMD_W || rx_byte == CMD_R)) begin
                     r_is_write <= (rx_byte == CMD_W);
                     r_nak      <= 1'b0;
                     r_state    <= GET_ADDR;
                  end else begin
                     r_nak   <= 1'b1;
                     r_state <= EXEC;
                  end
               end
            end
            GET_ADDR: begin
               if (rx_valid) begin
                  r_addr <= rx_byte[ADDR_W-1:0];
                  if (rx_err || w_addr_bad) begin
                     r_nak   <= 1'b1;
                     r_state <= EXEC;
                  end else if (r_is_write) begin
                     r_state <= GET_DATA;
                  end else begin
                     r_state <= EXEC;
                  end
               end
            end
            GET_DATA: begin
               if (rx_valid) begin
                  r_data  <= rx_byte;
                  r_nak   <= rx_err;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               overrun <= rx_valid;
               r_reply <= r_nak ? NAK : (r_is_write ? ACK : r_mem[r_addr]);
               r_state <= SEND;
            end
            SEND: begin
               overrun <= rx_valid;
               if (!tx_busy) begin
                  tx_start    <= 1'b1;
                  tx_byte     <= r_reply;
                  r_seen_busy <= 1'b0;
                  r_state     <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               overrun <= rx_valid;
               if (tx_busy) begin
                  r_seen_busy <= 1'b1;
               end else if (r_seen_busy) begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
`ifdef RS232_MEM_TIMEOUT_EN
         // Overrides the case above only when no byte arrived, so the abort never races a transition.
         if (r_state == GET_ADDR || r_state == GET_DATA) begin
            if (rx_valid) begin
               r_tmo <= '0;
            end else if (clk_rs232_en) begin
               if (r_tmo == TW'(TIMEOUT_TICKS - 1)) begin
                  r_tmo   <= '0;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
         end else begin
            r_tmo <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rs232_mem_cmd.sv
// Self-checking bench for rs232_mem_cmd: byte-level protocol model, scripted transmitter, random traffic.
module tb_rs232_mem_cmd;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 2**ADDR_W;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic       hold = 1'b0;
   logic       xmit = 1'b0;
   logic       tx_busy;
   logic [7:0] tx_byte;
   logic       tx_start;
   logic       busy;
   logic       overrun;

   assign tx_busy = hold | xmit;

   rs232_mem_cmd #(.ADDR_W(ADDR_W), .TIMEOUT_TICKS(32)) dut (
      .clk(clk), .rst(rst), .clk_rs232_en(en),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
      .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
      .busy(busy), .overrun(overrun)
   );

   initial forever #5 clk = ~clk;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         exp_start = -1;
   int         exp_ovr = -1;
   int         n_starts = 0;
   int         txlen = 3;
   bit         cmp_en = 1'b0;
   logic [7:0] exp_reply = 8'h00;
   logic [7:0] last_tx = 8'h00;
   logic [7:0] ref_mem [DEPTH];
   bit         written [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: decides how many bytes a command consumes and what the reply must be.
   task automatic model_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input bit e0, input bit e1, input bit e2,
                            output int n, output logic [7:0] rep);
      if (e0 || (b0 != 8'h57 && b0 != 8'h52)) begin
         n = 1; rep = 8'h15;
      end else if (e1 || b1 >= DEPTH) begin
         n = 2; rep = 8'h15;
      end else if (b0 == 8'h52) begin
         n = 2; rep = ref_mem[b1[ADDR_W-1:0]];
      end else if (e2) begin
         n = 3; rep = 8'h15;
      end else begin
         n = 3; rep = 8'h06;
         ref_mem[b1[ADDR_W-1:0]] = b2;
         written[b1[ADDR_W-1:0]] = 1'b1;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit e, output int k);
      rx_byte = b; rx_err = e; rx_valid = 1'b1; k = cyc;
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_err = 1'b0;
   endtask

   task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input bit e0, input bit e1, input bit e2,
                         input int hold_cyc, input bit inject);
      int n, k, t, prev;
      logic [7:0] rep;
      model_cmd(b0, b1, b2, e0, e1, e2, n, rep);
      prev  = n_starts;
      txlen = $urandom_range(2, 5);
      if (hold_cyc > 0) hold = 1'b1;
      send_byte(b0, e0, k);
      if (n > 1) begin step($urandom_range(0, 3)); send_byte(b1, e1, k); end
      if (n > 2) begin step($urandom_range(0, 3)); send_byte(b2, e2, k); end
      exp_reply = rep;
      if (hold_cyc > 0) begin
         while (cyc < k + 2 + hold_cyc) step(1);
         check("busy while tx held", {31'd0, busy}, 32'd1);
         hold = 1'b0;
         exp_start = cyc + 1;
      end else begin
         exp_start = k + 3;
      end
      t = 0;
      while (n_starts == prev && t < 60) begin step(1); t++; end
      check("tx_start count", n_starts - prev, 32'd1);
      if (inject) begin
         rx_byte = $urandom; rx_valid = 1'b1; exp_ovr = cyc + 1;
         step(1);
         rx_valid = 1'b0;
      end
      t = 0;
      while (busy !== 1'b0 && t < 100) begin step(1); t++; end
      check("busy after reply", {31'd0, busy}, 32'd0);
      exp_start = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      exp_start = -1;
   endtask

   initial begin
      int k, prev, kind;
      logic [7:0] a, d, c;

      fork
         forever begin @(posedge clk); cyc++; end
         forever begin @(posedge clk); #1; en = (cyc % 4 == 0); end
         forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
               @(posedge clk); #1; xmit = 1'b1;
               step(txlen);
               xmit = 1'b0;
            end
         end
         forever begin
            @(negedge clk);
            if (cmp_en) begin
               if (tx_start === 1'b1 || cyc == exp_start) begin
                  checks++;
                  if (!(tx_start === 1'b1 && cyc == exp_start && tx_byte === exp_reply)) begin
                     errors++;
                     $display("FAIL tx_start: cycle %0d start=%b byte=0x%h, required start at cycle %0d byte=0x%h",
                              cyc, tx_start, tx_byte, exp_start, exp_reply);
                  end
               end
               if (tx_start === 1'b1) begin last_tx = tx_byte; n_starts++; end
               checks++;
               if (overrun !== (cyc == exp_ovr)) begin
                  errors++;
                  $display("FAIL overrun: cycle %0d got %b, required %b", cyc, overrun, cyc == exp_ovr);
               end
            end
         end
      join_none

      rst = 1'b1;
      step(2);
      check("reset tx_start", {31'd0, tx_start}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset overrun", {31'd0, overrun}, 32'd0);
      check("reset tx_byte", {24'd0, tx_byte}, 32'h00);
      rst = 1'b0;
      cmp_en = 1'b1;
      step(2);

      do_cmd(8'h57, 8'h10, 8'hA5, 0, 0, 0, 0, 0);
      check("write ack", {24'd0, last_tx}, 32'h06);
      do_cmd(8'h52, 8'h10, 8'h00, 0, 0, 0, 6, 0);
      check("read after write", {24'd0, last_tx}, 32'hA5);
      do_cmd(8'h41, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      check("unknown cmd nak", {24'd0, last_tx}, 32'h15);
      do_cmd(8'h52, 8'h10, 8'h00, 0, 1, 0, 0, 0);
      check("addr rx_err nak", {24'd0, last_tx}, 32'h15);
      do_cmd(8'h57, 8'h40, 8'h11, 0, 0, 0, 0, 0);
      check("bad addr nak", {24'd0, last_tx}, 32'h15);
      do_cmd(8'h57, 8'h3F, 8'h5A, 0, 0, 0, 0, 0);
      do_cmd(8'h52, 8'h3F, 8'h00, 0, 0, 0, 0, 0);
      check("top addr read", {24'd0, last_tx}, 32'h5A);
      do_cmd(8'h57, 8'h10, 8'hEE, 0, 0, 1, 0, 0);
      check("data rx_err nak", {24'd0, last_tx}, 32'h15);
      do_cmd(8'h52, 8'h10, 8'h00, 0, 0, 0, 0, 1);
      check("read with overrun", {24'd0, last_tx}, 32'hA5);

      // Reset mid-command: partial write discarded.
      send_byte(8'h57, 0, k);
      send_byte(8'h10, 0, k);
      do_reset();
      check("busy after mid-cmd reset", {31'd0, busy}, 32'd0);
      do_cmd(8'h52, 8'h10, 8'h00, 0, 0, 0, 0, 0);
      check("read after aborted write", {24'd0, last_tx}, 32'hA5);

      // Reset while a reply is waiting for the transmitter: no tx_start afterwards.
      prev = n_starts;
      hold = 1'b1;
      send_byte(8'h52, 0, k);
      send_byte(8'h10, 0, k);
      step(4);
      do_reset();
      hold = 1'b0;
      step(10);
      check("no start after reset", n_starts - prev, 32'd0);
      check("idle after reset in send", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         a = 8'($urandom_range(0, DEPTH - 1));
         d = $urandom;
         case (kind)
            0: begin
               c = $urandom;
               while (c == 8'h57 || c == 8'h52) c = $urandom;
               do_cmd(c, a, d, 0, 0, 0, 0, 0);
            end
            1: do_cmd(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52, a, d,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 1, $urandom_range(0, 2) == 2, 0, 0);
            2: do_cmd(8'h52, 8'($urandom_range(DEPTH, 255)), d, 0, 0, 0, 0, 0);
            3, 4, 5, 6: do_cmd(8'h57, a, d, 0, 0, 0, $urandom_range(0, 1) * 3, $urandom_range(0, 3) == 0);
            default: begin
               if (written[a[ADDR_W-1:0]])
                  do_cmd(8'h52, a, 8'h00, 0, 0, 0, $urandom_range(0, 1) * 4, $urandom_range(0, 3) == 0);
               else
                  do_cmd(8'h57, a, d, 0, 0, 0, 0, 0);
            end
         endcase
         step($urandom_range(0, 4));
      end

`ifdef RS232_MEM_TIMEOUT_EN
      do_cmd(8'h57, 8'h00, 8'h33, 0, 0, 0, 0, 0);
      send_byte(8'h57, 0, k);
      step(29 * 4);
      check("busy before timeout", {31'd0, busy}, 32'd1);
      step(6 * 4);
      check("idle after timeout", {31'd0, busy}, 32'd0);
      do_cmd(8'h52, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      check("read after timeout", {24'd0, last_tx}, 32'h33);
`endif

      step(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
